// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer
// Frame sequencer between a UART receiver/transmitter pair and an 8-bit ALU.
// A frame is three received bytes in order: operand A, operand B, opcode.
// After the opcode arrives the ALU gets one cycle to settle on the new
// operands. Its result is then latched into tx_data and announced with a
// single-cycle tx_start pulse. The sequencer then waits for the transmitter
// to finish.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   rx_done_tick  1-cycle pulse, rx_data valid
//   rx_data       received byte
//   tx_done_tick  1-cycle pulse, transmitter finished
//   alu_w         ALU result (combinational from a, b, op)
//   a, b, op      registered ALU operands / opcode
//   tx_data       registered byte to transmit
//   tx_start      1-cycle pulse, start transmitting tx_data
//   busy          high whenever the sequencer is not waiting for operand A
//   rx_drop       sticky: a byte arrived while executing or transmitting
module alu_uart_sequencer #(
  parameter int DBIT           = 8,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int CNT_W          = 23
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_data,
  input  logic            tx_done_tick,
  input  logic [DBIT-1:0] alu_w,
  output logic [DBIT-1:0] a,
  output logic [DBIT-1:0] b,
  output logic [DBIT-1:0] op,
  output logic [DBIT-1:0] tx_data,
  output logic            tx_start,
  output logic            busy,
  output logic            rx_drop
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  // A zero timeout disables the inter-byte abort entirely.
  localparam bit               TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic [DBIT-1:0]   a_q, a_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic [DBIT-1:0]   op_q, op_d;
  logic [DBIT-1:0]   tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic              rx_drop_q, rx_drop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    rx_drop_d  = rx_drop_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      WAIT_A: begin
        if (rx_done_tick) begin
          a_d     = rx_data;
          cnt_d   = '0;
          state_d = WAIT_B;
        end
      end
      WAIT_B, WAIT_OP: begin
        // A byte arriving on the expiry cycle is still accepted.
        if (rx_done_tick) begin
          cnt_d = '0;
          if (state_q == WAIT_B) begin
            b_d     = rx_data;
            state_d = WAIT_OP;
          end else begin
            op_d    = rx_data;
            state_d = EXEC;
          end
        end else if (TO_EN) begin
          if (cnt_q == TO_LAST) begin
            cnt_d   = '0;
            state_d = WAIT_A;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      EXEC: begin
        // The ALU has seen the new opcode for this whole cycle.
        tx_data_d  = alu_w;
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
        if (rx_done_tick) rx_drop_d = 1'b1;
      end
      WAIT_TX: begin
        if (rx_done_tick) rx_drop_d = 1'b1;
        if (tx_done_tick) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase

    // Registered from the next state so it moves on the same edge as the FSM.
    busy_d = (state_d != WAIT_A);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_drop_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      rx_drop_q  <= rx_drop_d;
      cnt_q      <= cnt_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign op       = op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
module tb_alu_uart_sequencer;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       tx_done_tick;
  logic [7:0] alu_w;
  logic [7:0] a, b, op, tx_data;
  logic       tx_start, busy, rx_drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_uart_sequencer #(
    .DBIT(8),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_done_tick(rx_done_tick),
    .rx_data(rx_data),
    .tx_done_tick(tx_done_tick),
    .alu_w(alu_w),
    .a(a),
    .b(b),
    .op(op),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .busy(busy),
    .rx_drop(rx_drop)
  );

  // Stand-in 8-bit ALU; unknown opcodes return 0x40.
  function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] o);
    case (o)
      8'h20:   return x + y;
      8'h22:   return x - y;
      8'h24:   return x & y;
      8'h25:   return x | y;
      8'h26:   return x ^ y;
      8'h27:   return ~(x | y);
      8'h02:   return x >> y[2:0];
      default: return 8'h40;
    endcase
  endfunction

  assign alu_w = alu_f(a, b, op);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes collected so far, idle run length, and phase.
  // phase 0 = collecting, 1 = result pending, 2 = transmitting.
  logic [7:0] m_a, m_b, m_op, m_tx;
  bit         m_drop, m_start;
  int         m_k, m_idle, m_phase;
  logic [7:0] exp_q[$];

  // Monitor: every tx_start pulse must deliver the next expected result.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tx_start", 32'(tx_data), 32'hFFFF_FFFF);
      end else begin
        chk("tx_result", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input bit tk, input logic [7:0] d, input bit dn, input bit rs);
    rx_done_tick = tk;
    rx_data      = d;
    tx_done_tick = dn;
    reset        = rs;
    m_start      = 1'b0;
    if (rs) begin
      m_a = 0; m_b = 0; m_op = 0; m_tx = 0; m_drop = 0;
      m_k = 0; m_idle = 0; m_phase = 0;
    end else begin
      case (m_phase)
        0: begin
          if (tk) begin
            if (m_k == 0) m_a = d;
            else if (m_k == 1) m_b = d;
            else m_op = d;
            m_k++;
            m_idle = 0;
            if (m_k == 3) m_phase = 1;
          end else if (m_k > 0) begin
            if (m_idle == TO - 1) begin
              m_k = 0;
              m_idle = 0;
            end else begin
              m_idle++;
            end
          end
        end
        1: begin
          if (tk) m_drop = 1'b1;
          m_tx    = alu_f(m_a, m_b, m_op);
          m_start = 1'b1;
          m_phase = 2;
          exp_q.push_back(m_tx);
        end
        default: begin
          if (tk) m_drop = 1'b1;
          if (dn) begin
            m_phase = 0;
            m_k = 0;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    reset        = 1'b0;
    chk("a", 32'(a), 32'(m_a));
    chk("b", 32'(b), 32'(m_b));
    chk("op", 32'(op), 32'(m_op));
    chk("tx_data", 32'(tx_data), 32'(m_tx));
    chk("tx_start", 32'(tx_start), 32'(m_start));
    chk("busy", 32'(busy), 32'(!(m_phase == 0 && m_k == 0)));
    chk("rx_drop", 32'(rx_drop), 32'(m_drop));
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic txdone();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] o);
    send(x); send(y); send(o);
  endtask

  initial begin
    logic [7:0] ops [7] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02};
    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; tx_done_tick = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);

    // Add frame; tx_start two cycles after the opcode tick cycle.
    frame(8'h05, 8'h03, 8'h20);
    chk("add_start_early", 32'(tx_start), 32'd0);
    idle(1);
    chk("add_start", 32'(tx_start), 32'd1);
    chk("add_result", 32'(tx_data), 32'h08);
    idle(1);
    chk("add_start_cleared", 32'(tx_start), 32'd0);
    chk("add_busy", 32'(busy), 32'd1);
    txdone();
    chk("add_idle", 32'(busy), 32'd0);

    // Negative result and undefined opcode, back to back.
    frame(8'h03, 8'h05, 8'h22); idle(1);
    chk("sub_result", 32'(tx_data), 32'hFE);
    txdone();
    frame(8'h01, 8'h01, 8'h55); idle(1);
    chk("default_result", 32'(tx_data), 32'h40);
    txdone();

    // Timeout after operand A.
    send(8'h11); idle(TO);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_a_kept", 32'(a), 32'h11);
    frame(8'h02, 8'h02, 8'h20); idle(1);
    chk("after_timeout_result", 32'(tx_data), 32'h04);
    txdone();

    // Byte on the expiry cycle is accepted.
    send(8'h11); idle(TO - 1); send(8'h22);
    chk("expiry_busy", 32'(busy), 32'd1);
    chk("expiry_b", 32'(b), 32'h22);
    send(8'h20); idle(1); txdone();

    // Byte during transmit is dropped.
    frame(8'h01, 8'h02, 8'h20); idle(2); send(8'h77);
    chk("drop_flag", 32'(rx_drop), 32'd1);
    chk("drop_a", 32'(a), 32'h01);
    idle(3); txdone();
    frame(8'h04, 8'h04, 8'h20); idle(1);
    chk("post_drop_result", 32'(tx_data), 32'h08);
    txdone();
    chk("drop_sticky", 32'(rx_drop), 32'd1);

    // Reset mid-frame and mid-transmit, then a stray tx_done_tick.
    send(8'h09); step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_frame_a", 32'(a), 32'd0);
    frame(8'h01, 8'h02, 8'h20); idle(2); step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_drop", 32'(rx_drop), 32'd0);
    txdone();
    chk("stray_done_busy", 32'(busy), 32'd0);

    // Randomized traffic.
    for (int it = 0; it < 600; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8 || (r < 40 && m_phase == 2)) begin
        txdone();
      end else if (r < 72) begin
        if (m_phase == 0 && m_k == 2 && $urandom_range(0, 9) < 8)
          send(ops[$urandom_range(0, 6)]);
        else
          send(8'($urandom));
      end else if (r < 90) begin
        idle($urandom_range(1, 5));
      end else if (r < 97) begin
        idle($urandom_range(TO - 10, TO + 10));
      end else begin
        step(1'b0, 8'h00, 1'b0, 1'b1);
      end
    end

    if (m_phase != 0) begin
      idle(2);
      txdone();
    end
    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
